shift_register_n: RTL

//   Parametrised universal register: the multi-bit successor of our single-bit D flip-flop.
//   A WIDTH-bit register that can hold, parallel-load, shift left or right, rotate, or clear.
//   It has serial in/out at both ends and a shift counter that flags when a full word has passed.

---
 rtl/shift_reg_pkg.sv | 15 +
 rtl/shift_register_n_dff_cell.sv | 21 ++
 rtl/shift_register_n.sv | 106 ++++++++++
 3 files changed

// File: rtl/shift_reg_pkg.sv
// MODE encodings for the universal shift register.
// Shared with controllers and benches.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_ROTR  = 3'b101,
        MODE_CLEAR = 3'b110
    } mode_e;

endpackage

// File: rtl/shift_register_n_dff_cell.sv
// Single-bit storage cell.
// Synchronous active-high reset to a parametrised value, with an update enable.
module dff_cell #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    input  logic D,
    output logic Q
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q <= RESET_VALUE;
        end else if (EN) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/shift_register_n.sv
// WIDTH-bit universal register: hold, load, shift, rotate and clear.
// Includes a saturating shift counter and a registered FULL flag.
module shift_register_n
    import shift_reg_pkg::*;
#(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    localparam int                CW          = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [2:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN_L,
    input  logic             SIN_R,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT_L,
    output logic             SOUT_R,
    output logic [CW-1:0]    CNT,
    output logic             FULL
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] rotl;
    logic [WIDTH-1:0] rotr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             full;
    logic             step;
    logic             zero_cnt;

    // A one-bit register has no neighbours: shifts take the serial input, rotates keep Q.
    if (WIDTH == 1) begin : g_narrow
        assign shl  = SIN_R;
        assign shr  = SIN_L;
        assign rotl = q;
        assign rotr = q;
    end else begin : g_wide
        assign shl  = {q[WIDTH-2:0], SIN_R};
        assign shr  = {SIN_L, q[WIDTH-1:1]};
        assign rotl = {q[WIDTH-2:0], q[WIDTH-1]};
        assign rotr = {q[0], q[WIDTH-1:1]};
    end

    always_comb begin
        q_next   = q;
        step     = 1'b0;
        zero_cnt = 1'b0;
        case (MODE)
            MODE_LOAD:  begin q_next = D;    zero_cnt = 1'b1; end
            MODE_SHL:   begin q_next = shl;  step     = 1'b1; end
            MODE_SHR:   begin q_next = shr;  step     = 1'b1; end
            MODE_ROTL:  begin q_next = rotl; step     = 1'b1; end
            MODE_ROTR:  begin q_next = rotr; step     = 1'b1; end
            MODE_CLEAR: begin q_next = '0;   zero_cnt = 1'b1; end
            default:    ;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_cell #(
            .RESET_VALUE (RESET_VALUE[i])
        ) u_cell (
            .CLK   (CLK),
            .RESET (RESET),
            .EN    (EN),
            .D     (q_next[i]),
            .Q     (q[i])
        );
    end

    always_comb begin
        cnt_next = cnt;
        if (EN) begin
            if (zero_cnt) begin
                cnt_next = '0;
            end else if (step && (cnt != CNT_MAX)) begin
                cnt_next = cnt + CW'(1);
            end
        end
    end

    // FULL is derived from the next count so it changes on the same edge as CNT.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt  <= '0;
            full <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            full <= (cnt_next == CNT_MAX);
        end
    end

    assign Q      = q;
    assign SOUT_L = q[WIDTH-1];
    assign SOUT_R = q[0];
    assign CNT    = cnt;
    assign FULL   = full;

endmodule
